// File: rtl/reg16_write_arbiter.sv
// rtl/reg16_write_arbiter.sv - round-robin arbiter sharing the Register16 bank write path, plus read mux
// Optional feature: REG16_ARB_BYPASS_EN (same-cycle write-to-read forwarding on o_rd_data).
module reg16_write_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 16
) (
  input  logic                         i_clk,
  input  logic                         rst_n,
  input  logic                         i_req0_valid,
  input  logic [ADDR_W-1:0]            i_req0_addr,
  input  logic [DATA_W-1:0]            i_req0_data,
  output logic                         o_req0_ready,
  input  logic                         i_req1_valid,
  input  logic [ADDR_W-1:0]            i_req1_addr,
  input  logic [DATA_W-1:0]            i_req1_data,
  output logic                         o_req1_ready,
  output logic [NUM_REGS-1:0]          o_reg_load,
  output logic [DATA_W-1:0]            o_reg_data,
  input  logic [NUM_REGS*DATA_W-1:0]   i_reg_q,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic [7:0]                   o_wr_count
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state, state_nxt;
  logic                rr_ptr;
  logic                winner;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic [7:0]          wr_count;
  logic                grant;
  logic                grant_sel;
  logic                addr_ok;

  assign addr_ok    = int'(lat_addr) < NUM_REGS;
  assign o_reg_data = lat_data;
  assign o_wr_count = wr_count;

  always_ff @(posedge i_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    grant        = 1'b0;
    grant_sel    = 1'b0;
    o_reg_load   = '0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          grant     = 1'b1;
          // rr_ptr=1 means req1 wins a tie
          grant_sel = i_req1_valid && (!i_req0_valid || rr_ptr);
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        for (int k = 0; k < NUM_REGS; k++)
          o_reg_load[k] = (int'(lat_addr) == k);
        o_req0_ready = !winner;
        o_req1_ready = winner;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      winner   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      wr_count <= 8'h00;
    end else begin
      if (grant) begin
        winner   <= grant_sel;
        lat_addr <= grant_sel ? i_req1_addr : i_req0_addr;
        lat_data <= grant_sel ? i_req1_data : i_req0_data;
      end
      if (state == WRITE) begin
        rr_ptr <= ~winner;
        if (addr_ok && wr_count != 8'hFF)
          wr_count <= wr_count + 8'h01;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (int'(i_rd_addr) == k)
        o_rd_data = i_reg_q[k*DATA_W +: DATA_W];
`ifdef REG16_ARB_BYPASS_EN
    // forward the in-flight write so a same-cycle read sees the new value
    if (state == WRITE && addr_ok && i_rd_addr == lat_addr)
      o_rd_data = lat_data;
`endif
  end

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// tb/tb_reg16_write_arbiter.sv - directed self-checking bench for reg16_write_arbiter with a Register16 bank model
module tb_reg16_write_arbiter;
  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [3:0]  reg_load;
  logic [15:0] reg_data;
  logic [63:0] reg_q;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  wr_count;

  logic [15:0] bank [4];
  int tests = 0;
  int fails = 0;
  int ack0, ack1, last_w, alt_bad;

  reg16_write_arbiter dut (
    .i_clk(clk), .rst_n(rst_n),
    .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_data(req0_data), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_data(req1_data), .o_req1_ready(req1_ready),
    .o_reg_load(reg_load), .o_reg_data(reg_data), .i_reg_q(reg_q),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int k = 0; k < 4; k++) bank[k] = 16'h0000;
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (reg_load[k]) bank[k] <= reg_data;
  assign reg_q = {bank[3], bank[2], bank[1], bank[0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    rd_addr = 0;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("idle_load", 32'(reg_load), 32'h0);
    chk("idle_ready0", 32'(req0_ready), 32'h0);
    chk("idle_ready1", 32'(req1_ready), 32'h0);
    chk("idle_count", 32'(wr_count), 32'h0);

    // single req0 write
    req0_valid = 1; req0_addr = 2; req0_data = 16'hBEEF;
    step();
    chk("w1_load", 32'(reg_load), 32'h4);
    chk("w1_data", 32'(reg_data), 32'hBEEF);
    chk("w1_ready0", 32'(req0_ready), 32'h1);
    chk("w1_ready1", 32'(req1_ready), 32'h0);
    req0_valid = 0;
    step();
    rd_addr = 2; #1;
    chk("w1_read", 32'(rd_data), 32'hBEEF);
    chk("w1_load_off", 32'(reg_load), 32'h0);
    chk("w1_count", 32'(wr_count), 32'h1);

    // contention held from reset
    rst_n = 0;
    req0_valid = 1; req0_addr = 1; req0_data = 16'h1111;
    req1_valid = 1; req1_addr = 3; req1_data = 16'h3333;
    step();
    chk("c_rst_count", 32'(wr_count), 32'h0);
    rst_n = 1;
    step();
    chk("c_first_r0", 32'(req0_ready), 32'h1);
    chk("c_first_r1", 32'(req1_ready), 32'h0);
    chk("c_first_load", 32'(reg_load), 32'h2);
    req0_valid = 0;
    step();
    chk("c_gap_r1", 32'(req1_ready), 32'h0);
    step();
    chk("c_second_r1", 32'(req1_ready), 32'h1);
    chk("c_second_load", 32'(reg_load), 32'h8);
    chk("c_second_data", 32'(reg_data), 32'h3333);
    req1_valid = 0;
    step();
    chk("c_count", 32'(wr_count), 32'h2);
    rd_addr = 1; #1;
    chk("c_reg1", 32'(rd_data), 32'h1111);
    rd_addr = 3; #1;
    chk("c_reg3", 32'(rd_data), 32'h3333);

    // reset during WRITE
    req1_valid = 1; req1_addr = 0; req1_data = 16'h00AA;
    step();
    chk("r_write_r1", 32'(req1_ready), 32'h1);
    rst_n = 0; req1_valid = 0;
    step();
    chk("r_load", 32'(reg_load), 32'h0);
    chk("r_ready1", 32'(req1_ready), 32'h0);
    chk("r_count", 32'(wr_count), 32'h0);
    rst_n = 1;
    step();
    chk("r_load_after", 32'(reg_load), 32'h0);
    chk("r_ready1_after", 32'(req1_ready), 32'h0);
    chk("r_count_after", 32'(wr_count), 32'h0);

    // write-to-read forwarding
    rd_addr = 2;
    req0_valid = 1; req0_addr = 2; req0_data = 16'h5A5A;
    step();
`ifdef REG16_ARB_BYPASS_EN
    chk("fwd_write_cycle", 32'(rd_data), 32'h5A5A);
`else
    chk("fwd_write_cycle", 32'(rd_data), 32'hBEEF);
`endif
    req0_valid = 0;
    step();
    chk("fwd_after", 32'(rd_data), 32'h5A5A);
    chk("fwd_count", 32'(wr_count), 32'h1);

    // 300 contended writes, alternating
    ack0 = 0; ack1 = 0; last_w = -1; alt_bad = 0;
    req0_valid = 1; req0_addr = 0; req0_data = 16'hA000;
    req1_valid = 1; req1_addr = 1; req1_data = 16'hB000;
    for (int c = 0; c < 800 && (ack0 + ack1) < 300; c++) begin
      step();
      if (req0_ready) begin
        ack0++;
        if (last_w == 0) alt_bad++;
        last_w = 0;
        req0_data = req0_data + 16'h1;
      end
      if (req1_ready) begin
        ack1++;
        if (last_w == 1) alt_bad++;
        last_w = 1;
        req1_data = req1_data + 16'h1;
      end
    end
    req0_valid = 0; req1_valid = 0;
    step();
    chk("sat_total", 32'(ack0 + ack1), 32'd300);
    chk("sat_balance", 32'((ack0 > ack1 ? ack0 - ack1 : ack1 - ack0) <= 1), 32'h1);
    chk("sat_alternate", 32'(alt_bad), 32'h0);
    chk("sat_count", 32'(wr_count), 32'hFF);
    rd_addr = 0; #1;
    chk("sat_reg0", 32'(rd_data), 32'(16'hA000 + 16'(ack0) - 16'h1));
    rd_addr = 1; #1;
    chk("sat_reg1", 32'(rd_data), 32'(16'hB000 + 16'(ack1) - 16'h1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
